// File: rtl/sop_sweep_checker.sv
// Exhaustive 5-input sweep engine: drives abcde = 0..31, samples dut_out
// after SETTLE cycles per vector and checks it against a latched minterm mask.
module sop_sweep_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] exp_mask,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] captured,
  output logic [5:0]  err_cnt,
  output logic [4:0]  first_err,
  output logic        first_err_valid
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [3:0] SLAST = 4'(SETTLE - 1);

  state_t      state, state_nxt;
  logic [4:0]  idx;
  logic [3:0]  scnt;
  logic [31:0] exp_q;
  logic        sample;
  logic        mismatch;
  logic [5:0]  err_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and per-vector sample strobe
  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SWEEP;
      SWEEP: begin
        sample = (scnt == SLAST);
        if (sample && idx == 5'd31) state_nxt = DONE;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Compare the live response against the latched expectation
  always_comb begin
    mismatch = (dut_out != exp_q[idx]);
    err_nxt  = err_cnt + 6'(mismatch);
  end

  // Sweep index, settle counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx             <= '0;
      scnt            <= '0;
      exp_q           <= '0;
      captured        <= '0;
      err_cnt         <= '0;
      first_err       <= '0;
      first_err_valid <= 1'b0;
      pass            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_q           <= exp_mask;
            captured        <= '0;
            err_cnt         <= '0;
            first_err       <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
            idx             <= '0;
            scnt            <= '0;
          end
        end
        SWEEP: begin
          if (sample) begin
            captured[idx] <= dut_out;
            if (mismatch) err_cnt <= err_nxt;
            if (mismatch && !first_err_valid) begin
              first_err       <= idx;
              first_err_valid <= 1'b1;
            end
            // pass is resolved on the final sample so it is already valid in the DONE cycle
            if (idx == 5'd31) pass <= (err_nxt == 6'd0);
            else              idx  <= idx + 5'd1;
            scnt <= '0;
          end else begin
            scnt <= scnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stimulus and status outputs decoded from state
  always_comb begin
    {a, b, c, d, e} = (state == SWEEP) ? idx : 5'd0;
    busy            = (state == SWEEP);
    done            = (state == DONE);
  end

endmodule

// File: doc/sop_sweep_checker.md
# sop_sweep_checker

Self-checking sweep engine for 5-input combinational logic under test. On `start` it drives every input combination (abcde = 00000 … 11111, a is MSB) to the DUT, samples the DUT output after a programmable settle time, and compares it against a 32-bit expected minterm mask. It reports the captured truth table, the mismatch count and the first failing index. It forms the response/checking side of the SOP conversion flow and replaces manual waveform inspection of exhaustive stimulus.

## Interface
- `SETTLE`, default 1: cycles each vector is held before `dut_out` is sampled; legal range 1..15.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin sweep; honoured only in IDLE.
- `exp_mask`  in  32  expected output; bit i is the expected `dut_out` for vector i; latched on accepted `start`.
- `a`,`b`,`c`,`d`,`e`  out  1 each  stimulus to DUT; {a,b,c,d,e} = current index.
- `dut_out`  in  1  DUT response.
- `busy`  out  1  high from the cycle after accepted `start` through the last sample.
- `done`  out  1  one-cycle pulse when results are final.
- `pass`  out  1  1 iff `err_cnt`==0; valid from the `done` cycle; held.
- `captured`  out  32  bit i = sampled `dut_out` for vector i.
- `err_cnt`  out  6  number of mismatching vectors (0..32).
- `first_err`  out  5  lowest failing index; meaningful only when `first_err_valid`=1.
- `first_err_valid`  out  1  at least one mismatch seen.

## Operation
- FSM states: IDLE, SWEEP, DONE.
- IDLE: a..e=0, busy=0. On `start`=1: latch `exp_mask`; clear `captured`, `err_cnt`, `first_err`, `first_err_valid`, `pass`; idx=0; settle counter=0; go to SWEEP.
- SWEEP: {a,b,c,d,e}=idx. The settle counter counts 0..SETTLE-1. When it equals SETTLE-1: `captured[idx]`<=`dut_out`. If `dut_out`!=exp[idx], `err_cnt`+=1. If this is the first mismatch, `first_err`<=idx and `first_err_valid`<=1. Then, if idx==31, go to DONE; otherwise idx+=1 and reset the settle counter.
- DONE (1 cycle): `done`=1, busy=0, a..e=0, `pass`=(`err_cnt`==0). Next state is IDLE.
- `start` during SWEEP or DONE is ignored; it does not restart the sweep and is not queued.
- Results (`captured`, `err_cnt`, `first_err*`, `pass`) hold after DONE until the next accepted `start` or `rst`.
- `err_cnt` is 6 bits and cannot overflow, because the maximum count is 32.
- Reset (at any time, including mid-sweep) forces IDLE. Every output is 0: a..e, busy, done, pass, captured, err_cnt, first_err, first_err_valid. The latched mask and counters are also cleared.

## Timing
- `start` is sampled at edge T. From T+1: busy=1 and vector 0 is on a..e.
- Vector i is driven for cycles T+1+i·SETTLE … T+(i+1)·SETTLE.
- `dut_out` for vector i is sampled at edge T+1+(i+1)·SETTLE-1+1, which is the edge closing the vector's last held cycle. The updated `captured` is visible in the following cycle.
- `done`=1 in cycle T+1+32·SETTLE. Latency from the start edge to `done` is 32·SETTLE+1 cycles.
- `busy` falls in the `done` cycle. A new `start` is accepted in the cycle after `done`, at the earliest.
- The DUT must settle within SETTLE cycles. A registered DUT with 1 cycle of delay needs SETTLE≥2.

## Test plan
- SETTLE=1, DUT = a&b&c&d&e | ~(a|b|c|d|e), `exp_mask`=32'h8000_0001, pulse `start` -> `done` 33 cycles after the start edge; `captured`=32'h8000_0001, `err_cnt`=0, `pass`=1, `first_err_valid`=0.
- SETTLE=1, `dut_out` tied 0, `exp_mask`=32'h0000_0110 -> `captured`=0, `err_cnt`=2, `first_err`=4, `first_err_valid`=1, `pass`=0.
- SETTLE=1, `dut_out` tied 1, `exp_mask`=0 -> `captured`=32'hFFFF_FFFF, `err_cnt`=32, `first_err`=0, `pass`=0.
- SETTLE=3, DUT = a registered by 1 cycle, `exp_mask`=32'hFFFF_0000 -> `pass`=1. Each vector is held for exactly 3 cycles, in the order 0..31 on {a,b,c,d,e}. `done` arrives 97 cycles after start.
- Pulse `start` again at idx 5 -> the sweep continues unaffected. Assert `rst` at idx 10 -> the next cycle has busy=0, a..e=0, `err_cnt`=0, `captured`=0 and no `done`. A subsequent `start` runs a full 32-vector sweep.
